// File: rtl/regfile_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sched_pkg
// Description : Shared types and constants for the register-file write-port
//               scheduler (state encoding, register-file geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_sched_pkg;

    // Scheduler operating mode: zeroing sweep or arbitrated writes.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sched_state_e;

    // Geometry of the 32x32 register file served by the scheduler.
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_LAST_IDX   = 31;

endpackage : regfile_sched_pkg
`default_nettype wire

// File: rtl/regfile_write_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting at the pointer position and wrapping modulo
//               NUM_REQ; returns a one-hot grant and its encoded index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    // Two ordered passes: first requesters at or above the pointer, then the
    // wrapped-around ones below it. The first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (i < int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = IDX_WIDTH'(i);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_sched
// Description : Write-port scheduler for the 32x32 register file. Shares the
//               single write port among NUM_REQ requesters with round-robin
//               arbitration and a valid/ready handshake. After every reset it
//               optionally sweeps registers 1..last writing zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_sched
    import regfile_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH     = REGFILE_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         writeReg,
    output logic [DATA_WIDTH-1:0]         writeData,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    // The sweep ends on the highest register index (all ones).
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0]  LAST_REQ = IDX_WIDTH'(NUM_REQ - 1);

    localparam sched_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    sched_state_e            state_q,      state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q,    clr_idx_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q,     rr_ptr_d;
    logic                    write_q,      write_d;
    logic [ADDR_WIDTH-1:0]   write_reg_q,  write_reg_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic [IDX_WIDTH-1:0]    grant_id_q,   grant_id_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]      arb_grant;
    logic [IDX_WIDTH-1:0]    arb_idx;
    logic                    arb_valid;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;
    logic                    xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Select the winner's address/data slices using the one-hot grant.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Grants are offered only in RUN; the sweep owns the port otherwise.
    always_comb begin
        req_ready = (state_q == RUN) ? arb_grant : '0;
        xfer      = (state_q == RUN) && arb_valid;
        busy      = (state_q == CLEAR);
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    // Sweep writes one register per cycle; in RUN a handshake forwards the
    // winner, except that index 0 completes the handshake without writing.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        rr_ptr_d     = rr_ptr_q;
        write_d      = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;

        case (state_q)
            CLEAR: begin
                write_d      = 1'b1;
                write_reg_d  = clr_idx_q;
                write_data_d = '0;
                clr_idx_d    = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    write_d      = (win_addr != '0);
                    write_reg_d  = win_addr;
                    write_data_d = win_data;
                    grant_id_d   = arb_idx;
                    rr_ptr_d     = (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Register update with synchronous active-low reset; reset also cancels
    // any write that would otherwise be registered on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            clr_idx_q    <= ADDR_WIDTH'(1);
            rr_ptr_q     <= '0;
            write_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            write_q      <= write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    // Drive the register-file port straight from the output registers.
    always_comb begin
        write     = write_q;
        writeReg  = write_reg_q;
        writeData = write_data_q;
        grant_id  = grant_id_q;
    end

endmodule : regfile_write_sched
`default_nettype wire
